step_sequencer: RTL and testbench

Instruction-cycle sequencer for the 8-bit computer. It owns the T-state step counter, latches the instruction byte, and sequences fetch and execute microsteps, with an execute length set per opcode class. Its strobes drive the program counter, the instruction register load and the execute datapath. It supports free-run, single-step and halt.

---
 rtl/step_sequencer.sv | 109 ++++++++++
 tb/tb_step_sequencer.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// step_sequencer: T-state sequencer for the 8-bit computer.
// Fetch (T0/T1), opcode-sized execute (T2..T1+n) and halt, with free-run and single-step advance.
module step_sequencer #(
    parameter int MAX_T = 7
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run,
    input  logic       mode,
    input  logic       step_req,
    input  logic [7:0] bus_in,
    output logic [2:0] t_state,
    output logic [7:0] ir,
    output logic       pc_to_mar,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       exec_en,
    output logic       instr_done,
    output logic       step_ack,
    output logic       halted
);
    typedef enum logic [1:0] {FETCH0, FETCH1, EXEC, HALT} state_t;

    localparam logic [2:0] T_LIM = 3'(MAX_T);

    state_t     state_q, state_d;
    logic [2:0] t_q, t_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] op;
    logic [2:0] n, last;
    logic       go, wrap;

    function automatic logic [2:0] exec_len(input logic [3:0] opc);
        return opc == 4'h0 ? 3'd0 : opc <= 4'h3 ? 3'd3 : opc <= 4'h7 ? 3'd2 : 3'd1;
    endfunction

    // decode the byte being loaded at FETCH1, the latched one during EXEC
    assign op   = (state_q == FETCH1) ? bus_in[7:4] : ir_q[7:4];
    assign n    = exec_len(op);
    assign last = 3'd1 + n;
    assign wrap = (t_q >= last) || (t_q == T_LIM);
    // reset gates the strobes so they drop as soon as it asserts
    assign go   = reset && run && (!mode || step_req) && (state_q != HALT);

    assign t_state  = t_q;
    assign ir       = ir_q;
    assign step_ack = go && mode;
    assign halted   = (state_q == HALT);

    always_comb begin
        state_d    = state_q;
        t_d        = t_q;
        ir_d       = ir_q;
        pc_to_mar  = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        exec_en    = 1'b0;
        instr_done = 1'b0;
        if (go) begin
            case (state_q)
                FETCH0: begin
                    pc_to_mar = 1'b1;
                    state_d   = FETCH1;
                    t_d       = 3'd1;
                end
                FETCH1: begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    ir_d    = bus_in;
                    if (op == 4'hF) begin
                        instr_done = 1'b1;
                        state_d    = HALT;
                        t_d        = 3'd1;
                    end else if (n == 3'd0) begin
                        instr_done = 1'b1;
                        state_d    = FETCH0;
                        t_d        = 3'd0;
                    end else begin
                        state_d = EXEC;
                        t_d     = 3'd2;
                    end
                end
                EXEC: begin
                    exec_en = 1'b1;
                    if (wrap) begin
                        instr_done = 1'b1;
                        state_d    = FETCH0;
                        t_d        = 3'd0;
                    end else begin
                        t_d = t_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH0;
            t_q     <= 3'd0;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            ir_q    <= ir_d;
        end
    end
endmodule

// File: tb/tb_step_sequencer.sv
// tb_step_sequencer: directed checks of fetch/execute sequencing, halt, single-step, run freeze and async reset.
module tb_step_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       run = 1'b0;
    logic       mode = 1'b0;
    logic       step_req = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic [2:0] t_state;
    logic [7:0] ir;
    logic       pc_to_mar, ir_load, pc_inc, exec_en, instr_done, step_ack, halted;
    int         passed = 0;
    int         total = 0;

    step_sequencer dut (
        .clk(clk), .reset(reset), .run(run), .mode(mode), .step_req(step_req),
        .bus_in(bus_in), .t_state(t_state), .ir(ir), .pc_to_mar(pc_to_mar),
        .ir_load(ir_load), .pc_inc(pc_inc), .exec_en(exec_en),
        .instr_done(instr_done), .step_ack(step_ack), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    // leaves the bench just after a negedge, in the T0 cycle following reset release
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0; run = 1'b1; mode = 1'b0; step_req = 1'b0; bus_in = 8'h00;
        #1;
        total++; if (t_state !== 3'd0) $display("FAIL reset_t t_state=%0d want 0", t_state); else passed++;
        total++; if (ir !== 8'h00) $display("FAIL reset_ir ir=%h want 00", ir); else passed++;
        total++; if (halted !== 1'b0) $display("FAIL reset_halted halted=%b want 0", halted); else passed++;
        total++; if ({pc_to_mar, ir_load, pc_inc, exec_en, instr_done, step_ack} !== 6'b0)
            $display("FAIL reset_strobes strobes=%b want 000000", {pc_to_mar, ir_load, pc_inc, exec_en, instr_done, step_ack});
        else passed++;
        reset = 1'b1;
        #1;
        total++; if (pc_to_mar !== 1'b1) $display("FAIL reset_first_fetch pc_to_mar=%b want 1", pc_to_mar); else passed++;
    endtask

    task automatic test_nop();
        apply_reset();
        bus_in = 8'h00;
        for (int i = 0; i < 6; i++) begin
            #1;
            total++; if (t_state !== 3'(i % 2)) $display("FAIL nop_t cyc%0d t_state=%0d want %0d", i, t_state, i % 2); else passed++;
            total++; if (instr_done !== (i % 2 == 1)) $display("FAIL nop_done cyc%0d instr_done=%b", i, instr_done); else passed++;
            total++; if (pc_inc !== (i % 2 == 1)) $display("FAIL nop_pc_inc cyc%0d pc_inc=%b", i, pc_inc); else passed++;
            total++; if (pc_to_mar !== (i % 2 == 0)) $display("FAIL nop_pc_to_mar cyc%0d pc_to_mar=%b", i, pc_to_mar); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_exec_25();
        logic [2:0] exp_t[7] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0, 3'd1};
        logic       exp_x[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        logic       exp_d[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        apply_reset();
        bus_in = 8'h25;
        for (int i = 0; i < 7; i++) begin
            #1;
            total++; if (t_state !== exp_t[i]) $display("FAIL x25_t cyc%0d t_state=%0d want %0d", i, t_state, exp_t[i]); else passed++;
            total++; if (exec_en !== exp_x[i]) $display("FAIL x25_exec cyc%0d exec_en=%b want %b", i, exec_en, exp_x[i]); else passed++;
            total++; if (instr_done !== exp_d[i]) $display("FAIL x25_done cyc%0d instr_done=%b want %b", i, instr_done, exp_d[i]); else passed++;
            total++; if (ir !== ((i >= 2) ? 8'h25 : 8'h00)) $display("FAIL x25_ir cyc%0d ir=%h", i, ir); else passed++;
            @(negedge clk);
        end
    endtask

    task automatic test_halt();
        logic [2:0] exp_t[12] = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
        logic [7:0] bus_t[12] = '{8'h90, 8'h90, 8'h90, 8'h40, 8'h40, 8'h40, 8'h40, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0};
        apply_reset();
        for (int i = 0; i < 12; i++) begin
            bus_in = bus_t[i];
            #1;
            total++; if (t_state !== exp_t[i]) $display("FAIL halt_t cyc%0d t_state=%0d want %0d", i, t_state, exp_t[i]); else passed++;
            total++; if (instr_done !== (i == 2 || i == 6 || i == 8)) $display("FAIL halt_done cyc%0d instr_done=%b", i, instr_done); else passed++;
            total++; if (halted !== (i >= 9)) $display("FAIL halt_flag cyc%0d halted=%b", i, halted); else passed++;
            @(negedge clk);
        end
        mode = 1'b1; step_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (step_ack !== 1'b0) $display("FAIL halt_ack step_ack=%b want 0", step_ack); else passed++;
            total++; if (t_state !== 3'd1) $display("FAIL halt_hold t_state=%0d want 1", t_state); else passed++;
            total++; if ({pc_to_mar, ir_load, pc_inc, exec_en, instr_done} !== 5'b0)
                $display("FAIL halt_strobes strobes=%b want 00000", {pc_to_mar, ir_load, pc_inc, exec_en, instr_done});
            else passed++;
            total++; if (ir !== 8'hF0) $display("FAIL halt_ir ir=%h want f0", ir); else passed++;
            @(negedge clk);
        end
        mode = 1'b0; step_req = 1'b0;
        reset = 1'b0;
        #1;
        total++; if (halted !== 1'b0 || t_state !== 3'd0) $display("FAIL halt_reset halted=%b t_state=%0d want 0 0", halted, t_state); else passed++;
        reset = 1'b1;
        #1;
        total++; if (pc_to_mar !== 1'b1) $display("FAIL halt_restart pc_to_mar=%b want 1", pc_to_mar); else passed++;
        @(negedge clk);
        #1;
        total++; if (t_state !== 3'd1) $display("FAIL halt_restart_t t_state=%0d want 1", t_state); else passed++;
    endtask

    task automatic test_single_step();
        logic [2:0] seq[6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
        int k = 0;
        apply_reset();
        mode = 1'b1; bus_in = 8'h25;
        for (int i = 0; i < 18; i++) begin
            step_req = (i % 3 == 2);
            #1;
            total++; if (t_state !== seq[k]) $display("FAIL ss_t cyc%0d t_state=%0d want %0d", i, t_state, seq[k]); else passed++;
            total++; if (step_ack !== step_req) $display("FAIL ss_ack cyc%0d step_ack=%b want %b", i, step_ack, step_req); else passed++;
            total++; if (pc_to_mar !== (step_req && seq[k] == 3'd0)) $display("FAIL ss_pc_to_mar cyc%0d pc_to_mar=%b", i, pc_to_mar); else passed++;
            total++; if (exec_en !== (step_req && seq[k] >= 3'd2)) $display("FAIL ss_exec cyc%0d exec_en=%b", i, exec_en); else passed++;
            total++; if (instr_done !== (step_req && seq[k] == 3'd4)) $display("FAIL ss_done cyc%0d instr_done=%b", i, instr_done); else passed++;
            if (step_req) k++;
            @(negedge clk);
        end
        mode = 1'b0; step_req = 1'b0;
    endtask

    task automatic test_run_drop();
        logic [2:0] exp_t[10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd0};
        logic       run_t[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        apply_reset();
        bus_in = 8'h15;
        for (int i = 0; i < 10; i++) begin
            run = run_t[i];
            #1;
            total++; if (t_state !== exp_t[i]) $display("FAIL rd_t cyc%0d t_state=%0d want %0d", i, t_state, exp_t[i]); else passed++;
            total++; if (instr_done !== (i == 8)) $display("FAIL rd_done cyc%0d instr_done=%b", i, instr_done); else passed++;
            if (!run) begin
                total++; if ({pc_to_mar, ir_load, pc_inc, exec_en} !== 4'b0)
                    $display("FAIL rd_strobes cyc%0d strobes=%b want 0000", i, {pc_to_mar, ir_load, pc_inc, exec_en});
                else passed++;
                total++; if (ir !== 8'h15) $display("FAIL rd_ir cyc%0d ir=%h want 15", i, ir); else passed++;
            end
            @(negedge clk);
        end
        run = 1'b1;
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus_in = 8'h25;
        @(negedge clk);
        @(negedge clk);
        #1;
        total++; if (t_state !== 3'd2 || exec_en !== 1'b1) $display("FAIL ar_pre t_state=%0d exec_en=%b want 2 1", t_state, exec_en); else passed++;
        #2;
        reset = 1'b0;
        #1;
        total++; if (t_state !== 3'd0 || ir !== 8'h00) $display("FAIL ar_now t_state=%0d ir=%h want 0 00", t_state, ir); else passed++;
        total++; if ({exec_en, instr_done, pc_to_mar} !== 3'b0) $display("FAIL ar_strobes strobes=%b want 000", {exec_en, instr_done, pc_to_mar}); else passed++;
        @(negedge clk);
        #1;
        total++; if (instr_done !== 1'b0 || t_state !== 3'd0) $display("FAIL ar_held instr_done=%b t_state=%0d want 0 0", instr_done, t_state); else passed++;
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_nop();
        test_exec_25();
        test_halt();
        test_single_step();
        test_run_drop();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
